// File: rtl/md5_sched_pkg.sv
// Shared types and helpers for the md5 unit scheduler.
// State encoding, default sizes and the round-robin pointer width.
package md5_sched_pkg;

   localparam int DEF_NUM_UNITS = 4;
   localparam int DEF_POS_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

   // Width of a pointer able to index n units; never below 1 bit.
   function automatic int ptr_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/md5_unit_sched_rr_pick.sv
// Combinational round-robin selector: first idle unit at or above the
// pointer, wrapping at N. Reusable by any first-free arbiter.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_busy,
   input  logic [PW-1:0] i_rr_ptr,
   output logic [N-1:0]  o_grant_oh,
   output logic [PW-1:0] o_grant_idx,
   output logic          o_any_idle
);

   always_comb begin
      int idx;
      o_grant_oh  = '0;
      o_grant_idx = '0;
      o_any_idle  = 1'b0;
      idx         = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(i_rr_ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!o_any_idle && !i_busy[idx]) begin
            o_any_idle      = 1'b1;
            o_grant_oh[idx] = 1'b1;
            o_grant_idx     = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/md5_unit_sched.sv
// Dispatches candidate-string jobs to idle md5 units round-robin and folds
// their done/match pulses into one result: lowest matching byte position.
module md5_unit_sched
   import md5_sched_pkg::*;
#(
   parameter int NUM_UNITS = DEF_NUM_UNITS,
   parameter int POS_W     = DEF_POS_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sched_start,
   input  logic                 jobs_end,
   input  logic                 job_valid,
   input  logic [POS_W-1:0]     job_pos,
   output logic                 job_ready,
   output logic [NUM_UNITS-1:0] unit_start,
   input  logic [NUM_UNITS-1:0] unit_done,
   input  logic [NUM_UNITS-1:0] unit_match,
   output logic                 proc_done,
   output logic                 proc_match,
   output logic [POS_W-1:0]     proc_byte_pos,
   output logic [NUM_UNITS-1:0] units_busy,
   output logic                 sched_err,
   output logic [1:0]           sched_state
);

   localparam int PW = ptr_w(NUM_UNITS);

   sched_state_e         r_state, w_next;
   logic [NUM_UNITS-1:0] r_busy, r_unit_start;
   logic [NUM_UNITS-1:0] w_grant_oh, w_done_ok, w_hit;
   logic [PW-1:0]        r_rr_ptr, w_grant_idx;
   logic                 w_any_idle, w_accept;
   logic [POS_W-1:0]     r_pos [NUM_UNITS];
   logic                 r_match, r_err;
   logic [POS_W-1:0]     r_byte_pos;
   logic                 w_cand_vld;
   logic [POS_W-1:0]     w_cand;

   rr_pick #(.N(NUM_UNITS), .PW(PW)) u_pick (
      .i_busy      (r_busy),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant_oh  (w_grant_oh),
      .o_grant_idx (w_grant_idx),
      .o_any_idle  (w_any_idle)
   );

   // Handshake: a job transfers on any cycle where job_valid && job_ready.
   // job_ready depends only on registered state/busy, never on job_valid.
   assign job_ready = (r_state == ST_RUN) && w_any_idle;
   assign w_accept  = job_valid && job_ready;
   assign w_done_ok = unit_done & r_busy;
   assign w_hit     = w_done_ok & unit_match;

   // Strict less-than keeps the lowest index on equal positions.
   always_comb begin
      w_cand_vld = 1'b0;
      w_cand     = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (w_hit[k] && (!w_cand_vld || r_pos[k] < w_cand)) begin
            w_cand_vld = 1'b1;
            w_cand     = r_pos[k];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      if (sched_start) begin
         w_next = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN:   if (jobs_end) w_next = (r_busy == '0 && !w_accept) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (r_busy == '0) w_next = ST_DONE;
            default:  w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy       <= '0;
         r_unit_start <= '0;
         r_rr_ptr     <= '0;
         r_match      <= 1'b0;
         r_byte_pos   <= '0;
         r_err        <= 1'b0;
         for (int k = 0; k < NUM_UNITS; k++) r_pos[k] <= '0;
      end else begin
         r_unit_start <= '0;
         if (|(unit_done & ~r_busy)) r_err <= 1'b1;
         if (sched_start) begin
            r_busy     <= '0;
            r_rr_ptr   <= '0;
            r_match    <= 1'b0;
            r_byte_pos <= '0;
         end else begin
            r_busy <= (r_busy & ~w_done_ok) | (w_accept ? w_grant_oh : '0);
            if (w_accept) begin
               r_pos[w_grant_idx] <= job_pos;
               r_rr_ptr           <= (w_grant_idx == PW'(NUM_UNITS - 1)) ? '0 : w_grant_idx + 1'b1;
               r_unit_start       <= w_grant_oh;
            end
            if (w_cand_vld && (!r_match || w_cand < r_byte_pos)) begin
               r_match    <= 1'b1;
               r_byte_pos <= w_cand;
            end
         end
      end
   end

   assign unit_start    = r_unit_start;
   assign units_busy    = r_busy;
   assign proc_done     = (r_state == ST_DONE);
   assign proc_match    = r_match;
   assign proc_byte_pos = r_byte_pos;
   assign sched_err     = r_err;
   assign sched_state   = r_state;

endmodule

// File: doc/md5_unit_sched.md
Name: md5_unit_sched

Overview:
- Schedules candidate-string jobs from the char buffer onto NUM_UNITS parallel md5 units, using round-robin assignment among idle units.
- Tracks each unit's in-flight byte position and collects done/match results.
- Reports one aggregate result (done, match, lowest matching byte position) to the command parser's process handshake.
- Sits between char_buff/cmd_parser and the md5 unit array.

Parameters:
NUM_UNITS, 4, number of md5 units scheduled (2..16)
POS_W, 16, byte-position width (matches proc_byte_pos)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
sched_start  in  1  pulse: begin new process run (driven by proc_start)
jobs_end  in  1  pulse: no further jobs this run (may coincide with last accepted job)
job_valid  in  1  candidate job offered
job_pos  in  POS_W  byte position of candidate string
job_ready  out  1  scheduler accepts job this cycle
unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse to selected unit
unit_done  in  NUM_UNITS  per-unit one-cycle completion pulse
unit_match  in  NUM_UNITS  per-unit match flag, qualified by unit_done
proc_done  out  1  run complete (level)
proc_match  out  1  at least one unit matched this run
proc_byte_pos  out  POS_W  lowest matching job_pos
units_busy  out  NUM_UNITS  busy bitmap (debug/LEDs)
sched_err  out  1  sticky: unit_done seen from a non-busy unit

Behaviour:
- Reset: state=IDLE; all outputs 0; busy=0; rr_ptr=0; pos regs=0.
- States:
  - IDLE: job_ready=0.
  - RUN: accept jobs.
  - DRAIN: wait for busy==0.
  - DONE: proc_done=1.
- sched_start in any state (highest priority):
  - go RUN; clear busy, proc_match, proc_byte_pos, proc_done, rr_ptr, end_seen.
  - Does not clear sched_err.
  - Any in-flight work is aborted.
- job_ready = (state==RUN) && (busy != all-ones). Combinational from registered busy only.
- Accept = job_valid && job_ready:
  - grant = first idle unit scanning from rr_ptr upward with wrap, using registered busy.
  - busy[grant] set; pos_reg[grant] <= job_pos; rr_ptr <= grant+1 (wrap to 0 at NUM_UNITS).
  - unit_start[grant] pulses the cycle after accept (registered); at most one bit high.
- unit_done[k] with busy[k]=1:
  - clears busy[k] that cycle; the unit is eligible again next cycle.
  - done and accept on the same unit in one cycle cannot occur, because grant uses registered busy.
- unit_done[k] with busy[k]=0: ignored for results; sched_err <= 1.
- Match update, any number of simultaneous done+match:
  - candidate = min pos_reg over matching units; ties resolved to lowest index.
  - If !proc_match or candidate < proc_byte_pos: proc_byte_pos <= candidate and proc_match <= 1.
- jobs_end in RUN:
  - go DRAIN (same-cycle accept is still taken).
  - Go straight to DONE if busy==0, no accept that cycle, and no busy unit pending.
  - jobs_end outside RUN is ignored.
- DRAIN -> DONE on the cycle after busy becomes 0, which includes the final result update.
- DONE: proc_done, proc_match, proc_byte_pos held until the next sched_start or reset.
- Zero jobs then jobs_end: DONE with proc_match=0.
- proc_done rises 1 cycle after the last busy bit clears.
- Reset mid-run: immediate asynchronous clear to reset values.

Decomposition:
- Package md5_sched_pkg holds:
  - state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3, 2-bit);
  - default NUM_UNITS and POS_W;
  - a function for ceil-log2 rr_ptr width.
- Sub-module rr_pick (combinational round-robin first-idle selector: busy, rr_ptr -> grant one-hot, grant index, any_idle) is natural; it is reused by other arbiters.

Test Plan:
- NUM_UNITS=4, sched_start, 6 jobs pos 0..5 back-to-back, units complete 10 cycles after start, no match, jobs_end -> unit_start order 0,1,2,3, job_ready low until first done, then jobs 4->0 and 5->1; proc_done=1, proc_match=0.
- Same run with unit_match on the jobs at pos 3 and pos 1 completing in that order -> proc_byte_pos=1, proc_match=1.
- Units 1 and 2 finish in the same cycle, both matching, pos 7 and 4 -> proc_byte_pos=4.
- sched_start then jobs_end with no jobs -> proc_done=1 the next cycle, proc_match=0, unit_start never pulses.
- sched_start while 3 units are busy -> busy=0, proc_done=0; stale unit_done then sets sched_err=1 and proc_match is unchanged.
- reset_n asserted mid-DRAIN, asynchronous to clk -> all outputs 0 immediately, state IDLE, job_ready=0 after release.
